// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Define MULDIV_DIV_EN to include the divider; without it divide ops complete at once with result 0.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_iterate;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_result;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_final;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

    assign w_accept  = (r_state == IDLE) && in_valid && !kill;
    assign w_iterate = (r_state == CALC) && !kill;
    assign w_last    = (r_cnt == LAST_ITER);

    assign w_a_neg = a[WIDTH-1] &&
                     (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign w_b_neg = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
    assign w_sum         = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next    = {w_sum, r_prod[WIDTH-1:1]};
    assign w_prod_signed = r_neg ? -w_mul_next : w_mul_next;

`ifdef MULDIV_DIV_EN
    logic               r_neg_rem;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;
    logic               w_div_ovf;

    // r_prod holds {remainder, dividend/quotient}; the trial subtract's sign bit is the restore decision.
    assign w_trial    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_opnd};
    assign w_div_next = w_trial[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    assign w_quo      = w_div_next[WIDTH-1:0];
    assign w_rem      = w_div_next[2*WIDTH-1:WIDTH];

    assign w_div_zero    = (b == '0);
    assign w_div_ovf     = (op == OP_DIV || op == OP_REM) && (a == MOST_NEG) && (b == '1);
    assign w_fast        = op[2] && (w_div_zero || w_div_ovf);
    assign w_fast_result = op[1] ? (w_div_zero ? a : '0) : (w_div_zero ? '1 : MOST_NEG);

    assign w_step  = r_op[2] ? w_div_next : w_mul_next;
    assign w_final = !r_op[2] ? ((r_op == OP_MUL) ? w_prod_signed[WIDTH-1:0]
                                                  : w_prod_signed[2*WIDTH-1:WIDTH])
                   : r_op[1]  ? (r_neg_rem ? -w_rem : w_rem)
                              : (r_neg ? -w_quo : w_quo);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_neg_rem <= 1'b0;
        end else if (w_accept) begin
            r_neg_rem <= w_a_neg;
        end
    end
`else
    assign w_fast        = op[2];
    assign w_fast_result = '0;
    assign w_step        = w_mul_next;
    assign w_final       = (r_op == OP_MUL) ? w_prod_signed[WIDTH-1:0]
                                            : w_prod_signed[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = w_fast ? DONE : CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (kill) w_state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_prod   <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op   <= op;
                r_cnt  <= '0;
                r_prod <= {{WIDTH{1'b0}}, w_a_mag};
                r_opnd <= w_b_mag;
                r_neg  <= w_a_neg ^ w_b_neg;
                if (w_fast) r_result <= w_fast_result;
            end else if (w_iterate) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) r_result <= w_final;
            end
        end
    end

endmodule
